// File: rtl/debounce_pkg.sv
// Shared widths, repeat-phase encoding and 50 MHz timing defaults
// for the push-button debounce bank.
package debounce_pkg;

  localparam int DEB_20MS_50MHZ = 1_000_000;
  localparam int REP_DELAY_500MS_50MHZ = 25_000_000;
  localparam int REP_PERIOD_100MS_50MHZ = 5_000_000;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_PERIOD = 2'd2
  } rep_phase_e;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, stable-time filter,
// press/release pulses and auto-repeat of press while held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = REP_PERIOD_100MS_50MHZ
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W =
    cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam bit REP_EN = (REPEAT_DELAY > 0);

  localparam logic [CNT_W-1:0] DEB_TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_TERM =
    CNT_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PER_TERM =
    CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic             sync1_q;
  logic             sync2_q;
  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] rep_cnt_q;
  rep_phase_e       phase_q;
  logic             press_q;
  logic             rel_q;
  logic             rise;
  logic             fall;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == DEB_TERM) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise = state_d & ~state_q;
  assign fall = ~state_d & state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= 1'b0;
      cnt_q     <= '0;
      rep_cnt_q <= '0;
      phase_q   <= REP_IDLE;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= rise;
      rel_q   <= fall;
      // release wins over any repeat due on the same edge
      if (fall || !REP_EN) begin
        phase_q   <= REP_IDLE;
        rep_cnt_q <= '0;
      end else if (rise) begin
        phase_q   <= REP_DELAY;
        rep_cnt_q <= '0;
      end else begin
        unique case (phase_q)
          REP_DELAY: begin
            if (rep_cnt_q == DLY_TERM) begin
              press_q   <= 1'b1;
              phase_q   <= REP_PERIOD;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          REP_PERIOD: begin
            if (rep_cnt_q == PER_TERM) begin
              press_q   <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          default: begin
            phase_q   <= REP_IDLE;
            rep_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced button channels with optional
// pull-up inversion ahead of the synchronisers.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = REP_PERIOD_100MS_50MHZ
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic [CHANNELS-1:0] Button,
  output logic [CHANNELS-1:0] State,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release
);

  logic [CHANNELS-1:0] btn;

  assign btn = Button ^ {CHANNELS{ACTIVE_LOW != 0}};

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (Clk),
      .rst_ni   (nReset),
      .btn_i    (btn[g]),
      .state_o  (State[g]),
      .press_o  (Press[g]),
      .release_o(Release[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Three bank variants (plain, auto-repeat, active-low) driven
// with directed and random button activity against a reference.
module tb_debounce_bank;

  localparam int NI  = 3;
  localparam int DEB = 8;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] btn [NI];
  logic [1:0] st  [NI];
  logic [1:0] pr  [NI];
  logic [1:0] rl  [NI];
  logic [1:0] st0, st1, st2;
  logic [1:0] pr0, pr1, pr2;
  logic [1:0] rl0, rl1, rl2;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  debounce_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(0),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) u_plain (
    .Clk(Clk), .nReset(nReset), .Button(btn[0]),
    .State(st0), .Press(pr0), .Release(rl0)
  );

  debounce_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(0),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) u_rep (
    .Clk(Clk), .nReset(nReset), .Button(btn[1]),
    .State(st1), .Press(pr1), .Release(rl1)
  );

  debounce_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) u_al (
    .Clk(Clk), .nReset(nReset), .Button(btn[2]),
    .State(st2), .Press(pr2), .Release(rl2)
  );

  assign st[0] = st0;
  assign st[1] = st1;
  assign st[2] = st2;
  assign pr[0] = pr0;
  assign pr[1] = pr1;
  assign pr[2] = pr2;
  assign rl[0] = rl0;
  assign rl[1] = rl1;
  assign rl[2] = rl2;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int rd_of(input int i);
    return (i == 1) ? 20 : 0;
  endfunction

  function automatic int rp_of(input int i);
    return (i == 1) ? 5 : 1;
  endfunction

  function automatic logic al_of(input int i);
    return (i == 2);
  endfunction

  // Reference: State toggles after DEB consecutive sampled
  // disagreements; repeats derived from time held since rise.
  logic [1:0] m_s1 [NI];
  logic [1:0] m_s2 [NI];
  logic [1:0] m_st [NI];
  logic [1:0] m_pr [NI];
  logic [1:0] m_rl [NI];
  int         m_run  [NI][2];
  int         m_held [NI][2];

  always @(posedge Clk or negedge nReset) begin
    logic ns;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!nReset) begin
          m_s1[i][c] = 1'b0;
          m_s2[i][c] = 1'b0;
          m_st[i][c] = 1'b0;
          m_pr[i][c] = 1'b0;
          m_rl[i][c] = 1'b0;
          m_run[i][c] = 0;
          m_held[i][c] = 0;
        end else begin
          ns = m_st[i][c];
          m_pr[i][c] = 1'b0;
          m_rl[i][c] = 1'b0;
          if (m_s2[i][c] != m_st[i][c]) begin
            m_run[i][c]++;
            if (m_run[i][c] == DEB) begin
              ns = ~m_st[i][c];
              m_run[i][c] = 0;
            end
          end else begin
            m_run[i][c] = 0;
          end
          if (ns && !m_st[i][c]) begin
            m_pr[i][c] = 1'b1;
            m_held[i][c] = 0;
          end else if (!ns && m_st[i][c]) begin
            m_rl[i][c] = 1'b1;
          end else if (m_st[i][c]) begin
            m_held[i][c]++;
            if (rd_of(i) > 0 && m_held[i][c] >= rd_of(i) &&
                (m_held[i][c] - rd_of(i)) % rp_of(i) == 0)
              m_pr[i][c] = 1'b1;
          end
          m_st[i][c] = ns;
          m_s2[i][c] = m_s1[i][c];
          m_s1[i][c] = btn[i][c] ^ al_of(i);
        end
      end
    end
  end

  always @(negedge Clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("state%0d", i), 32'(st[i]), 32'(m_st[i]));
      check($sformatf("press%0d", i), 32'(pr[i]), 32'(m_pr[i]));
      check($sformatf("rel%0d", i), 32'(rl[i]), 32'(m_rl[i]));
    end
  end

  int cyc = 0;
  int pcnt0 = 0;
  int rep_rel = 0;
  int rep_q[$];

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (pr[0][0]) pcnt0++;
    if (pr[1][0]) rep_q.push_back(cyc);
    if (rl[1][0]) rep_rel++;
  end

  initial begin
    int pc;
    bit found;
    int exp_off[5];
    exp_off = '{0, 20, 25, 30, 35};
    btn[0] = 2'b00;
    btn[1] = 2'b00;
    btn[2] = 2'b11;
    nReset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_state", 32'(st[0]), 0);
    check("rst_press", 32'(pr[0]), 0);
    check("rst_rel", 32'(rl[0]), 0);
    @(negedge Clk) nReset = 1'b1;

    // clean press on ch0
    @(negedge Clk) btn[0][0] = 1'b1;
    repeat (9) @(posedge Clk);
    #1 check("t1_pre", 32'(st[0]), 0);
    @(posedge Clk);
    #1;
    check("t1_state", 32'(st[0]), 32'h1);
    check("t1_press", 32'(pr[0]), 32'h1);
    @(posedge Clk);
    #1 check("t1_pulse_end", 32'(pr[0]), 0);

    // release
    @(negedge Clk) btn[0][0] = 1'b0;
    repeat (9) @(posedge Clk);
    #1 check("t3_pre", 32'(st[0]), 32'h1);
    @(posedge Clk);
    #1;
    check("t3_state", 32'(st[0]), 0);
    check("t3_rel", 32'(rl[0]), 32'h1);
    check("t3_press", 32'(pr[0]), 0);
    repeat (3) @(posedge Clk);

    // bounce then stable press
    pc = pcnt0;
    @(negedge Clk) btn[0][0] = 1'b1;
    repeat (5) @(negedge Clk);
    btn[0][0] = 1'b0;
    repeat (2) @(negedge Clk);
    btn[0][0] = 1'b1;
    repeat (9) @(posedge Clk);
    #1 check("t2_pre", 32'(st[0]), 0);
    check("t2_nopulse", 32'(pcnt0 - pc), 0);
    @(posedge Clk);
    #1 check("t2_state", 32'(st[0]), 32'h1);
    repeat (5) @(posedge Clk);
    #1 check("t2_one_press", 32'(pcnt0 - pc), 1);
    @(negedge Clk) btn[0][0] = 1'b0;
    repeat (12) @(posedge Clk);

    // auto-repeat
    rep_q.delete();
    rep_rel = 0;
    found = 0;
    @(negedge Clk) btn[1][0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk);
      #1;
      if (st[1][0]) begin
        found = 1;
        break;
      end
    end
    check("t4_rise", 32'(found), 1);
    repeat (39) @(posedge Clk);
    @(negedge Clk) btn[1][0] = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    check("t4_count", 32'(rep_q.size()), 7);
    check("t4_rel", 32'(rep_rel), 1);
    for (int k = 0; k < 5 && k < rep_q.size(); k++)
      check($sformatf("t4_off%0d", k),
            32'(rep_q[k] - rep_q[0]), 32'(exp_off[k]));

    // reset mid-operation
    @(negedge Clk) btn[0][1] = 1'b1;
    repeat (10) @(posedge Clk);
    #1 check("t5_ch1_up", 32'(st[0]), 32'h2);
    @(negedge Clk) btn[0][0] = 1'b1;
    repeat (7) @(posedge Clk);
    #2 nReset = 1'b0;
    #1;
    check("t5_rst_state", 32'(st[0]), 0);
    check("t5_rst_press", 32'(pr[0]), 0);
    check("t5_rst_rel", 32'(rl[0]), 0);
    repeat (3) @(posedge Clk);
    #1 check("t5_hold", 32'(st[0] | pr[0] | rl[0]), 0);
    @(negedge Clk) nReset = 1'b1;
    repeat (9) @(posedge Clk);
    #1 check("t5_pre", 32'(st[0]), 0);
    @(posedge Clk);
    #1;
    check("t5_state", 32'(st[0]), 32'h3);
    check("t5_press", 32'(pr[0]), 32'h3);
    @(negedge Clk) btn[0] = 2'b00;
    repeat (12) @(posedge Clk);

    // active-low channels
    @(negedge Clk) btn[2] = 2'b01;
    repeat (10) @(posedge Clk);
    #1 check("t6_ch1", 32'(st[2]), 32'h2);
    @(negedge Clk) btn[2] = 2'b11;
    repeat (12) @(posedge Clk);
    @(negedge Clk) btn[2] = 2'b00;
    repeat (10) @(posedge Clk);
    #1;
    check("t6_state", 32'(st[2]), 32'h3);
    check("t6_press", 32'(pr[2]), 32'h3);
    @(negedge Clk) btn[2] = 2'b11;
    repeat (12) @(posedge Clk);

    // random activity, model compared every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < 2; c++)
          if ($urandom_range((i == 1) ? 39 : 11, 0) == 0)
            btn[i][c] = ~btn[i][c];
    end
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
